sat_addsub_pipe: RTL

Parametrised, two-stage pipelined saturating add/subtract unit with valid/ready handshakes on input and output.
- Supports signed add or subtract per transaction.
- Saturation is selectable per transaction; with saturation off, results wrap.
- Produces zero, negative and overflow flags with each result.
- Sits between the decode/operand-fetch stage and writeback, replacing the fixed 16-bit combinational subtractor.

---
 rtl/sat_addsub_pipe_pkg.sv | 23 ++
 rtl/sat_addsub_pipe_if.sv | 33 +++
 rtl/sat_addsub_core.sv | 44 ++++
 rtl/sat_addsub_pipe.sv | 102 ++++++++++
 4 files changed

// File: rtl/sat_addsub_pipe_pkg.sv
// Shared definitions for the saturating add/subtract unit: operation encoding
// and the two's-complement saturation limits for a given operand width.
package sat_addsub_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Limits are returned in a 64-bit container; callers keep the low WIDTH bits.
    localparam int LIMIT_W = 64;

    typedef struct packed {
        logic [LIMIT_W-1:0] max_pos;
        logic [LIMIT_W-1:0] max_neg;
    } sat_limits_t;

    function automatic sat_limits_t sat_limits(input int width);
        sat_limits_t lim;
        lim.max_neg = 64'd1 << (width - 1);
        lim.max_pos = lim.max_neg - 64'd1;
        return lim;
    endfunction

endpackage

// File: rtl/sat_addsub_pipe_if.sv
// Operand and result channels of the saturating add/subtract pipeline.
// master = producer/consumer side, slave = the arithmetic unit.
interface sat_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    // Both channels use valid/ready: a beat moves on a rising edge where valid
    // and ready are both high; once valid is raised by the unit, the payload
    // stays stable until ready is seen. ready may depend combinationally on the
    // downstream ready, never on the same channel's valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_op;
    logic             in_sat;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_zr;
    logic             out_neg;
    logic             out_ov;

    modport master (
        output in_valid, in_a, in_b, in_op, in_sat, out_ready,
        input  in_ready, out_valid, out_res, out_zr, out_neg, out_ov
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_sat, out_ready,
        output in_ready, out_valid, out_res, out_zr, out_neg, out_ov
    );
endinterface

// File: rtl/sat_addsub_core.sv
// Combinational signed add/subtract with optional saturation and result flags.
// Shared by the pipelined unit and the single-cycle ALU path.
module sat_addsub_core
    import sat_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             sat,
    output logic [WIDTH-1:0] res,
    output logic             zr,
    output logic             neg,
    output logic             ov
);
    localparam sat_limits_t      LIM     = sat_limits(WIDTH);
    localparam logic [WIDTH-1:0] MAX_POS = LIM.max_pos[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_NEG = LIM.max_neg[WIDTH-1:0];
    localparam int               MSB     = WIDTH - 1;

    logic [WIDTH-1:0] r;

    always_comb begin
        r = (op == OP_SUB) ? (a - b) : (a + b);

        // Overflow only when operands (after negating b for sub) share a sign
        // that the truncated result does not.
        if (op == OP_SUB) begin
            ov = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
        end else begin
            ov = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
        end

        if (ov && sat) begin
            res = a[MSB] ? MAX_NEG : MAX_POS;
        end else begin
            res = r;
        end

        zr  = (res == '0);
        neg = res[MSB];
    end
endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage pipelined saturating add/subtract with valid/ready on both sides.
// Optional SAT_ADDSUB_STICKY_OV_EN adds a sticky overflow flag with clear.
module sat_addsub_pipe
    import sat_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    sat_addsub_pipe_if.slave      bus
`ifdef SAT_ADDSUB_STICKY_OV_EN
    ,
    output logic                  ov_sticky,
    input  logic                  ov_sticky_clr
`endif
);
    logic             s1_valid;
    logic             s2_valid;
    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_op;
    logic             s1_sat;

    logic [WIDTH-1:0] c_res;
    logic             c_zr;
    logic             c_neg;
    logic             c_ov;

    // A stage may load when it is empty or its content leaves this cycle.
    assign s2_en         = ~s2_valid | bus.out_ready;
    assign s1_en         = ~s1_valid | s2_en;
    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_en) s1_valid <= bus.in_valid;
            if (s2_en) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_op  <= OP_ADD;
            s1_sat <= 1'b0;
        end else if (s1_en && bus.in_valid) begin
            s1_a   <= bus.in_a;
            s1_b   <= bus.in_b;
            s1_op  <= bus.in_op;
            s1_sat <= bus.in_sat;
        end
    end

    sat_addsub_core #(.WIDTH(WIDTH)) u_core (
        .a   (s1_a),
        .b   (s1_b),
        .op  (s1_op),
        .sat (s1_sat),
        .res (c_res),
        .zr  (c_zr),
        .neg (c_neg),
        .ov  (c_ov)
    );

    // Result registers only move with s2_en, which holds them while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_res <= '0;
            bus.out_zr  <= 1'b0;
            bus.out_neg <= 1'b0;
            bus.out_ov  <= 1'b0;
        end else if (s2_en && s1_valid) begin
            bus.out_res <= c_res;
            bus.out_zr  <= c_zr;
            bus.out_neg <= c_neg;
            bus.out_ov  <= c_ov;
        end
    end

`ifdef SAT_ADDSUB_STICKY_OV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_sticky <= 1'b0;
        end else if (bus.out_valid && bus.out_ready && bus.out_ov) begin
            ov_sticky <= 1'b1;
        end else if (ov_sticky_clr) begin
            ov_sticky <= 1'b0;
        end
    end
`endif
endmodule
